mul_div_unit: RTL
=================

# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS CPU. It takes both operands straight from the register file's two read ports. It runs MULT/MULTU/DIV/DIVU over 32 clock cycles and raises `busy` so control can freeze the PC. Its HI/LO outputs feed the writeback mux for MFHI/MFLO, which returns results to the register file.

## Interface
Parameters: none (fixed 32-bit datapath, 32 iterations).

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  launch operation `op` on `a`, `b` (accepted only when `busy`=0)
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- `a`  in  32  rs operand / dividend
- `b`  in  32  rt operand / divisor
- `hi_we`  in  1  MTHI: HI <= `wdata`
- `lo_we`  in  1  MTLO: LO <= `wdata`
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  operation in progress; control stalls the pipeline while high
- `done`  out  1  one-cycle pulse: HI/LO just updated by a completed operation
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, RUN. A 6-bit iteration counter counts 0..31.
- Reset (`rst`=0, any time, including mid-RUN): state IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0, internal shift registers cleared. The aborted operation leaves no trace.
- IDLE, `start`=1: latch `op`, record operand signs, and load magnitudes.
  - Magnitudes are |a| and |b| for signed ops, raw values for unsigned ops.
  - Go to RUN. The counter is set to 0.
- IDLE, `start`=0: `hi_we`/`lo_we` write `wdata` into HI/LO. Both may assert in the same cycle.
- IDLE, `start`=1 with `hi_we` or `lo_we` asserted: `start` wins and the MTHI/MTLO write is dropped.
- RUN: one iteration per cycle.
  - Multiply: shift-add, 64-bit product accumulator.
  - Divide: restoring division, 33-bit partial remainder, 32-bit quotient shift register.
  - `start`, `hi_we` and `lo_we` are ignored.
- RUN, counter=31: apply the sign fix and write HI/LO, assert `done` for the next cycle, return to IDLE.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit product. For MULT the product is negated if sign(a) xor sign(b).
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed sign fix: quotient negated if sign(a) xor sign(b); remainder takes the sign of `a`.
- Boundaries:
  - Divide by zero (any div op): LO=32'hFFFFFFFF, HI=`a` (original, unmodified). No sign fix; still takes 32 cycles.
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
  - Operands equal to 32'h80000000 under MULT: magnitude 2^31 is handled exactly, with no overflow in the 64-bit product.

## Timing
- Let E0 be the rising edge sampling `start`=1 in IDLE.
  - `busy`=1 from after E0 through E32.
  - HI/LO update at E32.
  - `busy`=0 and `done`=1 after E32; `done` falls after E33.
- Latency: 32 cycles from accept to result. A new `start` can be accepted at E33 (back-to-back issue).
- `a`, `b` and `op` need only be valid at E0. Later changes have no effect.
- MTHI/MTLO take effect at the sampling edge. `hi`/`lo` change the following cycle.
- `hi`/`lo` are register outputs: stable throughout RUN, holding the previous values.

## Test plan
- Reset, then MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> `busy` high 32 cycles; HI=32'hFFFFFFFE, LO=32'h00000001; `done` single pulse.
- MULT a=-7 (32'hFFFFFFF9), b=6 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFD6. DIV a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU a=100, b=0 -> LO=32'hFFFFFFFF, HI=100. DIV a=32'h80000000, b=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- During RUN, pulse `start` with new operands and `hi_we`=1 with `wdata`=32'h1234 -> both ignored; the original result is delivered at E32.
- IDLE: `hi_we`=`lo_we`=1 with `wdata`=32'hA5A5A5A5 -> HI=LO=32'hA5A5A5A5. Same cycle with `start`=1 -> write dropped, operation launched.
- Assert `rst`=0 asynchronously at iteration 15 -> `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, a fresh DIVU 17/5 -> LO=3, HI=2.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, signs fixed at the end.
module mul_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, stateNext;
   logic [5:0]  cnt;
   logic        isDiv;
   logic        negRes;
   logic        negRem;
   logic        divZero;
   logic [31:0] aOrig;
   logic [63:0] acc;
   logic [31:0] mcand;
   logic [32:0] rem;
   logic [31:0] quo;

   logic        signA, signB;
   logic [31:0] magA, magB;
   logic [32:0] sum;
   logic [63:0] accStep;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic [32:0] remStep;
   logic [31:0] quoStep;
   logic [63:0] prodFix;
   logic [31:0] quoFix;
   logic [31:0] remFix;
   logic        lastIter;

   assign busy     = (state == RUN);
   assign lastIter = (cnt == 6'd31);

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (start) stateNext = RUN;
         RUN:  if (lastIter) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // op[0]=0 selects the signed variants
   always_comb begin
      signA = ~op[0] & a[31];
      signB = ~op[0] & b[31];
      magA  = signA ? -a : a;
      magB  = signB ? -b : b;
   end

   always_comb begin
      sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
      accStep = {sum, acc[31:1]};
      shifted = {rem[31:0], quo[31]};
      diff    = shifted - {1'b0, mcand};
      remStep = diff[32] ? shifted : diff;
      quoStep = {quo[30:0], ~diff[32]};
      prodFix = negRes ? -accStep : accStep;
      quoFix  = negRes ? -quoStep : quoStep;
      remFix  = negRem ? -remStep[31:0] : remStep[31:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 6'd0;
         done    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         isDiv   <= 1'b0;
         negRes  <= 1'b0;
         negRem  <= 1'b0;
         divZero <= 1'b0;
         aOrig   <= 32'd0;
         acc     <= 64'd0;
         mcand   <= 32'd0;
         rem     <= 33'd0;
         quo     <= 32'd0;
      end else begin
         state <= stateNext;
         done  <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               cnt     <= 6'd0;
               isDiv   <= op[1];
               negRes  <= signA ^ signB;
               negRem  <= signA & op[1];
               divZero <= op[1] & (b == 32'd0);
               aOrig   <= a;
               acc     <= {32'd0, magA};
               mcand   <= magB;
               rem     <= 33'd0;
               quo     <= magA;
            end else begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
            end
         end else begin
            cnt <= cnt + 6'd1;
            acc <= accStep;
            rem <= remStep;
            quo <= quoStep;
            if (lastIter) begin
               done <= 1'b1;
               if (!isDiv) begin
                  {hi, lo} <= prodFix;
               end else if (divZero) begin
                  hi <= aOrig;
                  lo <= 32'hFFFF_FFFF;
               end else begin
                  hi <= remFix;
                  lo <= quoFix;
               end
            end
         end
      end
   end

endmodule
